// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : Shared types and constants for the UART command frame parser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

  localparam logic [7:0] CMD_HEADER = 8'hA5;

  typedef enum logic [7:0] {
    CMD_VOL  = 8'h01,
    CMD_RATE = 8'h02,
    CMD_PLAY = 8'h03,
    CMD_REC  = 8'h04,
    CMD_STOP = 8'h05
  } cmd_e;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARG   = 2'd1,
    CHECK = 2'd2,
    EXEC  = 2'd3
  } parser_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_parser_if.sv
// ============================================================================
// Module   : uart_cmd_parser_if
// Brief    : Setting-word input and configuration/pulse outputs of the parser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_parser_if;
  logic        i_set;
  logic [15:0] i_setdata;
  logic [15:0] o_volume;
  logic [15:0] o_rate_div;
  logic        o_play;
  logic        o_record;
  logic        o_stop;
  logic        o_err;
  logic [7:0]  o_err_cnt;
  logic        o_busy;

  modport master (
    output i_set, i_setdata,
    input  o_volume, o_rate_div, o_play, o_record, o_stop,
           o_err, o_err_cnt, o_busy
  );

  modport slave (
    input  i_set, i_setdata,
    output o_volume, o_rate_div, o_play, o_record, o_stop,
           o_err, o_err_cnt, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
// ============================================================================
// Module   : uart_cmd_timeout
// Brief    : Inter-word stall counter; expired flags TIMEOUT-1 idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_timeout #(
  parameter int TIMEOUT = 50_000_000
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  input  wire logic clear,
  input  wire logic run,
  output logic      expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != C_TERM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = run && (r_cnt == C_TERM);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Validates {header,arg,check} word frames and drives config regs.
//            Optional stall timeout built when UART_CMD_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int          TIMEOUT      = 50_000_000,
  parameter logic [15:0] DEF_VOLUME   = 16'h0080,
  parameter logic [15:0] DEF_RATE_DIV = 16'd1042
) (
  input wire logic         i_clk,
  input wire logic         i_rst,
  uart_cmd_parser_if.slave bus
);

  parser_state_e r_state;
  logic [15:0]   r_w0;
  logic [15:0]   r_w1;
  logic [15:0]   r_volume;
  logic [15:0]   r_rate_div;
  logic          r_play;
  logic          r_record;
  logic          r_stop;
  logic          r_err;
  logic [7:0]    r_err_cnt;
  logic          r_busy;
  logic          w_expired;

`ifdef UART_CMD_TIMEOUT_EN
  logic w_clear;
  logic w_run;

  assign w_clear = (r_state == HUNT) || bus.i_set;
  assign w_run   = (r_state == ARG) || (r_state == CHECK);

  uart_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clear   (w_clear),
    .run     (w_run),
    .expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= HUNT;
      r_w0       <= '0;
      r_w1       <= '0;
      r_volume   <= DEF_VOLUME;
      r_rate_div <= DEF_RATE_DIV;
      r_play     <= 1'b0;
      r_record   <= 1'b0;
      r_stop     <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_play   <= 1'b0;
      r_record <= 1'b0;
      r_stop   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        HUNT: begin
          if (bus.i_set && (bus.i_setdata[15:8] == CMD_HEADER)) begin
            r_w0    <= bus.i_setdata;
            r_state <= ARG;
            r_busy  <= 1'b1;
          end
        end
        ARG: begin
          if (bus.i_set) begin
            r_w1    <= bus.i_setdata;
            r_state <= CHECK;
          end else if (w_expired) begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
            r_state   <= HUNT;
            r_busy    <= 1'b0;
          end
        end
        CHECK: begin
          // An arriving word always takes priority over a same-cycle expiry.
          if (bus.i_set) begin
            r_busy <= 1'b0;
            if (bus.i_setdata == (r_w0 ^ r_w1)) begin
              r_state <= EXEC;
            end else begin
              r_err     <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= HUNT;
            end
          end else if (w_expired) begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
            r_state   <= HUNT;
            r_busy    <= 1'b0;
          end
        end
        EXEC: begin
          r_state <= HUNT;
          case (r_w0[7:0])
            CMD_VOL:  r_volume   <= r_w1;
            CMD_RATE: r_rate_div <= (r_w1 == 16'd0) ? 16'd1 : r_w1;
            CMD_PLAY: r_play     <= 1'b1;
            CMD_REC:  r_record   <= 1'b1;
            CMD_STOP: r_stop     <= 1'b1;
            default: begin
              r_err     <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
            end
          endcase
        end
        default: begin
          r_state <= HUNT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_volume   = r_volume;
  assign bus.o_rate_div = r_rate_div;
  assign bus.o_play     = r_play;
  assign bus.o_record   = r_record;
  assign bus.o_stop     = r_stop;
  assign bus.o_err      = r_err;
  assign bus.o_err_cnt  = r_err_cnt;
  assign bus.o_busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module   : tb_uart_cmd_parser
// Brief    : Directed self-checking bench for uart_cmd_parser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   play_pulses;
  int   err_pulses;
  int   overlap_cycles;
  int   snap_play;
  int   snap_err;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(
    .TIMEOUT      (16),
    .DEF_VOLUME   (16'h0080),
    .DEF_RATE_DIV (16'd1042)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_play === 1'b1) play_pulses++;
    if (bus.o_err === 1'b1) err_pulses++;
    if ((32'(bus.o_play) + 32'(bus.o_record) + 32'(bus.o_stop)) > 32'd1) overlap_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word is sampled on the edge after it is driven; returns 1ns past that edge.
  task automatic strobe(input logic [15:0] word);
    @(posedge clk);
    #1;
    bus.i_set     = 1'b1;
    bus.i_setdata = word;
    @(posedge clk);
    #1;
    bus.i_set     = 1'b0;
    bus.i_setdata = 16'h0000;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vol"},  32'(bus.o_volume),   32'h0080);
    check({tag, "_rate"}, 32'(bus.o_rate_div), 32'd1042);
    check({tag, "_puls"}, {28'd0, bus.o_play, bus.o_record, bus.o_stop, bus.o_err}, 32'd0);
    check({tag, "_ecnt"}, 32'(bus.o_err_cnt),  32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy),     32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    play_pulses = 0; err_pulses = 0; overlap_cycles = 0;
    bus.i_set = 1'b0;
    bus.i_setdata = 16'h0000;
    rst_n = 1'b0;
    step();
    step();
    check_reset_values("rst");
    rst_n = 1'b1;
    step();

    // Volume frame
    strobe(16'hA501);
    check("vol_busy_w0", 32'(bus.o_busy), 32'd1);
    strobe(16'h1234);
    strobe(16'hB735);
    check("vol_early", 32'(bus.o_volume), 32'h0080);
    step();
    check("vol_value", 32'(bus.o_volume), 32'h1234);
    check("vol_ecnt",  32'(bus.o_err_cnt), 32'd0);
    check("vol_rate",  32'(bus.o_rate_div), 32'd1042);

    // Bad checksum
    strobe(16'hA502);
    strobe(16'h0010);
    strobe(16'h0000);
    check("bad_err_on",  32'(bus.o_err), 32'd1);
    check("bad_busy",    32'(bus.o_busy), 32'd0);
    step();
    check("bad_err_off", 32'(bus.o_err), 32'd0);
    check("bad_rate",    32'(bus.o_rate_div), 32'd1042);
    check("bad_ecnt",    32'(bus.o_err_cnt), 32'd1);

    // Garbage words then play
    snap_play = play_pulses;
    snap_err  = err_pulses;
    strobe(16'h1234);
    strobe(16'hFFFF);
    check("garb_busy", 32'(bus.o_busy), 32'd0);
    strobe(16'hA503);
    strobe(16'h0000);
    strobe(16'hA503);
    check("play_early", 32'(bus.o_play), 32'd0);
    step();
    check("play_on", 32'(bus.o_play), 32'd1);
    step();
    check("play_off", 32'(bus.o_play), 32'd0);
    step();
    check("play_count", 32'(play_pulses - snap_play), 32'd1);
    check("play_noerr", 32'(err_pulses - snap_err), 32'd0);
    check("play_ecnt",  32'(bus.o_err_cnt), 32'd1);

    // Clamp then unknown command, from a fresh reset
    pulse_reset();
    strobe(16'hA502);
    strobe(16'h0000);
    strobe(16'hA502);
    step();
    check("clamp_rate", 32'(bus.o_rate_div), 32'd1);
    strobe(16'hA577);
    strobe(16'h0001);
    strobe(16'hA576);
    check("unk_err_early", 32'(bus.o_err), 32'd0);
    step();
    check("unk_err_on", 32'(bus.o_err), 32'd1);
    check("unk_ecnt",   32'(bus.o_err_cnt), 32'd1);
    check("unk_rate",   32'(bus.o_rate_div), 32'd1);
    check("unk_vol",    32'(bus.o_volume), 32'h0080);
    step();
    check("unk_err_off", 32'(bus.o_err), 32'd0);

`ifdef UART_CMD_TIMEOUT_EN
    // Stall after header: expiry on the 16th idle edge
    strobe(16'hA505);
    for (int i = 0; i < 15; i++) step();
    check("to_err_pre",  32'(bus.o_err), 32'd0);
    check("to_busy_pre", 32'(bus.o_busy), 32'd1);
    step();
    check("to_err_on",  32'(bus.o_err), 32'd1);
    check("to_busy_off", 32'(bus.o_busy), 32'd0);
    check("to_ecnt",    32'(bus.o_err_cnt), 32'd2);
    // Word landing on the expiry edge wins
    strobe(16'hA505);
    for (int i = 0; i < 15; i++) step();
    bus.i_set     = 1'b1;
    bus.i_setdata = 16'h0007;
    step();
    bus.i_set     = 1'b0;
    bus.i_setdata = 16'h0000;
    check("to_race_err",  32'(bus.o_err), 32'd0);
    check("to_race_busy", 32'(bus.o_busy), 32'd1);
    strobe(16'hA502);
    step();
    check("to_race_stop", 32'(bus.o_stop), 32'd1);
    check("to_race_ecnt", 32'(bus.o_err_cnt), 32'd2);
`else
    // Without the timeout a partial frame waits indefinitely
    strobe(16'hA505);
    for (int i = 0; i < 40; i++) step();
    check("nto_busy", 32'(bus.o_busy), 32'd1);
    check("nto_ecnt", 32'(bus.o_err_cnt), 32'd1);
    strobe(16'h0000);
    strobe(16'hA505);
    step();
    check("nto_stop", 32'(bus.o_stop), 32'd1);
`endif

    // Reset mid-frame
    snap_err = err_pulses;
    strobe(16'hA504);
    check("mid_busy", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    step();
    check_reset_values("mid");
    rst_n = 1'b1;
    step();
    check("mid_noerr", 32'(err_pulses - snap_err), 32'd0);
    strobe(16'hA504);
    strobe(16'h0000);
    strobe(16'hA504);
    step();
    check("rec_on", 32'(bus.o_record), 32'd1);
    step();
    check("rec_off", 32'(bus.o_record), 32'd0);
    check("overlap", 32'(overlap_cycles), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
